// File: rtl/fir_filter_param.sv
// fir_filter_param: pipelined parameterised FIR filter with run-time loadable coefficients.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   enable, clear   global advance, synchronous flush (clear wins)
//   rIn1, dataIn1   input sample valid and signed sample
//   coef_we/addr/data  coefficient write port (writes to addr>=TAPS ignored)
//   sat_mode        0 = wrap, 1 = saturate on output
//   dataOut1, r_out, ovf  filtered sample, valid pulse, sticky overflow
module fir_filter_param #(
  parameter int N      = 16,
  parameter int TAPS   = 4,
  parameter int COEF_W = 16,
  parameter int AW     = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     rIn1,
  input  logic signed [N-1:0]      dataIn1,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     sat_mode,
  output logic [N-1:0]             dataOut1,
  output logic                     r_out,
  output logic                     ovf
);
  localparam int PW = N + COEF_W;
  localparam int SW = PW + $clog2(TAPS);
  logic signed [N-1:0]      x_q    [TAPS-1];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [PW-1:0]     p_d    [TAPS];
  logic signed [PW-1:0]     p_q    [TAPS];
  logic signed [SW-1:0]     sum_d, acc_q;
  logic                     v1_q, v2_q, in_range;
  logic [N-1:0]             y_d;
  // Products are formed at the accepting edge so the sample sees the
  // coefficients that existed before that edge; later writes cannot touch it.
  always_comb begin
    p_d[0] = PW'(coef_q[0]) * PW'(dataIn1);
    for (int k = 1; k < TAPS; k++) p_d[k] = PW'(coef_q[k]) * PW'(x_q[k-1]);
    sum_d = '0;
    for (int k = 0; k < TAPS; k++) sum_d = sum_d + SW'(p_q[k]);
    // In range iff every bit above the N-bit sign position equals the sign.
    in_range = (&acc_q[SW-1:N-1]) | ~(|acc_q[SW-1:N-1]);
    y_d = (sat_mode && !in_range)
        ? (acc_q[SW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
        : acc_q[N-1:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q      <= '{default: '0};
      p_q      <= '{default: '0};
      acc_q    <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      r_out    <= 1'b0;
      dataOut1 <= '0;
      ovf      <= 1'b0;
    end else if (clear) begin
      x_q   <= '{default: '0};
      p_q   <= '{default: '0};
      acc_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      r_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (enable) begin
      if (rIn1) begin
        x_q[0] <= dataIn1;
        for (int k = 1; k < TAPS - 1; k++) x_q[k] <= x_q[k-1];
      end
      p_q   <= p_d;
      v1_q  <= rIn1;
      acc_q <= sum_d;
      v2_q  <= v1_q;
      r_out <= v2_q;
      if (v2_q) begin
        dataOut1 <= y_d;
        ovf      <= ovf | ~in_range;
      end
    end
  end
  // Coefficient storage ignores enable and clear; only reset restores defaults.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) coef_q[k] <= COEF_W'(TAPS - k);
    end else if (coef_we) begin
      for (int k = 0; k < TAPS; k++)
        if (coef_addr == AW'(k)) coef_q[k] <= coef_data;
    end
  end
endmodule

// File: tb/tb_fir_filter_param.sv
module tb_fir_filter_param;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable, clear, rIn1, coef_we, sat_mode;
  logic [15:0] dataIn1, coef_data, dataOut1;
  logic [2:0]  coef_addr;
  logic        r_out, ovf;
  int total = 0;
  int bad   = 0;

  fir_filter_param #(.N(16), .TAPS(4), .COEF_W(16), .AW(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .rIn1(rIn1),
    .dataIn1(dataIn1), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .sat_mode(sat_mode), .dataOut1(dataOut1),
    .r_out(r_out), .ovf(ovf));

  always #5 clk = ~clk;

  typedef struct {longint acc; int age;} pend_t;
  pend_t       pend[$];
  longint      hist[4];
  longint      coef[4];
  logic        exp_r = 1'b0;
  logic        exp_o = 1'b0;
  logic [15:0] exp_y = '0;
  logic [15:0] got[$];
  logic        last_en = 1'b0;

  task automatic model_reset();
    pend.delete();
    for (int k = 0; k < 4; k++) begin hist[k] = 0; coef[k] = 4 - k; end
    exp_r = 1'b0; exp_o = 1'b0; exp_y = '0;
  endtask

  always @(negedge rst) model_reset();

  // Abstract model: history of accepted samples, results queued with an age
  // counted in enabled edges; a result is presented when its age reaches zero.
  always @(posedge clk) begin : mdl
    longint acc;
    logic [63:0] a;
    last_en = enable && !clear;
    if (rst) begin
      if (clear) begin
        pend.delete();
        for (int k = 0; k < 4; k++) hist[k] = 0;
        exp_r = 1'b0; exp_o = 1'b0;
      end else if (enable) begin
        exp_r = 1'b0;
        foreach (pend[i]) pend[i].age--;
        if (pend.size() > 0 && pend[0].age == 0) begin
          acc = pend[0].acc; a = acc;
          exp_r = 1'b1;
          exp_y = !sat_mode ? a[15:0] : acc > 32767 ? 16'h7FFF : acc < -32768 ? 16'h8000 : a[15:0];
          if (acc > 32767 || acc < -32768) exp_o = 1'b1;
          void'(pend.pop_front());
        end
        if (rIn1) begin
          for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
          hist[0] = longint'($signed(dataIn1));
          acc = 0;
          for (int k = 0; k < 4; k++) acc += coef[k] * hist[k];
          pend.push_back('{acc, 2});
        end
      end
      if (coef_we && coef_addr < 3'd4) coef[coef_addr] = longint'($signed(coef_data));
    end
  end

  always @(negedge clk) begin
    total++;
    if (r_out !== exp_r) begin bad++; $display("FAIL r_out t=%0t got=%b want=%b", $time, r_out, exp_r); end
    total++;
    if (ovf !== exp_o) begin bad++; $display("FAIL ovf t=%0t got=%b want=%b", $time, ovf, exp_o); end
    if (exp_r) begin
      total++;
      if (dataOut1 !== exp_y) begin bad++; $display("FAIL dataOut1 t=%0t got=%h want=%h", $time, dataOut1, exp_y); end
    end
    if (r_out && last_en) got.push_back(dataOut1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s got=%h want=%h", name, act, exp); end
  endtask

  task automatic chk_list(input string name, input int e[$]);
    chk({name, "_count"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++)
      chk(name, {16'h0, got[i]}, e[i]);
  endtask

  task automatic drv(input logic v, input logic [15:0] d, input logic en = 1'b1, input logic clr = 1'b0);
    rIn1 = v; dataIn1 = d; enable = en; clear = clr; coef_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [15:0] d);
    rIn1 = 1'b0; enable = 1'b1; clear = 1'b0;
    coef_we = 1'b1; coef_addr = addr; coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 16'h0);
  endtask

  initial begin
    int e[$];
    model_reset();
    rst = 1'b0; enable = 1'b1; clear = 1'b0; rIn1 = 1'b0; dataIn1 = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; sat_mode = 1'b0;
    #12;
    chk("reset_dout", {16'h0, dataOut1}, 0);
    chk("reset_rout", {31'h0, r_out}, 0);
    chk("reset_ovf", {31'h0, ovf}, 0);
    @(negedge clk); rst = 1'b1;
    // impulse
    got.delete();
    drv(1, 16'd1); repeat (4) drv(1, 16'd0); idle(4);
    e = '{4, 3, 2, 1, 0}; chk_list("impulse", e);
    // step with gaps
    drv(0, 0, 1, 1); got.delete();
    repeat (5) begin drv(1, 16'd1); drv(0, 16'd9); end
    idle(4);
    e = '{4, 7, 9, 10, 10}; chk_list("step_gaps", e);
    // overflow, wrap mode
    drv(0, 0, 1, 1); got.delete();
    repeat (4) drv(1, 16'h7FFF);
    idle(4);
    chk("ovf_wrap_first", {16'h0, got[0]}, 32'hFFFC);
    chk("ovf_set", {31'h0, ovf}, 1);
    drv(0, 0, 1, 1);
    chk("ovf_cleared", {31'h0, ovf}, 0);
    // overflow, saturate mode
    sat_mode = 1'b1; got.delete();
    repeat (4) drv(1, 16'h7FFF);
    idle(4);
    e = '{32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF}; chk_list("ovf_sat", e);
    chk("ovf_sat_flag", {31'h0, ovf}, 1);
    sat_mode = 1'b0;
    // coefficient load and out-of-range write
    drv(0, 0, 1, 1); got.delete();
    wr(3'd0, 16'hFFFF);
    wr(3'd4, 16'h1234);
    drv(1, 16'd1); repeat (3) drv(1, 16'd0); idle(4);
    e = '{32'hFFFF, 3, 2, 1}; chk_list("coef_load", e);
    wr(3'd0, 16'd4);
    // stall mid-stream
    drv(0, 0, 1, 1); got.delete();
    drv(1, 16'd1); drv(1, 16'd2); drv(1, 16'd3);
    repeat (3) drv(1, 16'd77, 1'b0);
    drv(1, 16'd4); drv(1, 16'd5); drv(1, 16'd6);
    idle(4);
    e = '{4, 11, 20, 30, 40, 50}; chk_list("stall", e);
    // clear mid-stream
    drv(1, 16'd5); drv(1, 16'd6); drv(1, 16'd7);
    drv(0, 0, 1, 1); got.delete();
    drv(1, 16'd1); repeat (3) drv(1, 16'd0); idle(4);
    e = '{4, 3, 2, 1}; chk_list("clear_flush", e);
    // async reset with results in flight
    wr(3'd1, 16'd9);
    drv(1, 16'd1); drv(1, 16'd2);
    #2 rst = 1'b0;
    #1;
    chk("arst_dout", {16'h0, dataOut1}, 0);
    chk("arst_rout", {31'h0, r_out}, 0);
    chk("arst_ovf", {31'h0, ovf}, 0);
    got.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(3);
    chk("arst_no_stale", got.size(), 0);
    drv(1, 16'd1); repeat (3) drv(1, 16'd0); idle(4);
    e = '{4, 3, 2, 1}; chk_list("arst_coefs", e);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_filter_param.md
FIR_FILTER_PARAM -- requirements
Module: fir_filter_param

Interface
REQ-001 Parameter N, default 16: signed two's-complement sample width.
REQ-002 Parameter TAPS, default 4, legal range 2..16: filter length.
REQ-003 Parameter COEF_W, default 16: signed two's-complement coefficient width.
REQ-004 Parameter AW, default clog2(TAPS): coefficient address width.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  global advance; low freezes the datapath.
REQ-008 clear  input  1  synchronous flush of delay line, pipeline and ovf.
REQ-009 rIn1  input  1  input sample valid.
REQ-010 dataIn1  input  N  input sample.
REQ-011 coef_we  input  1  coefficient write strobe.
REQ-012 coef_addr  input  AW  coefficient index k.
REQ-013 coef_data  input  COEF_W  coefficient value.
REQ-014 sat_mode  input  1  output mode: 0 = wrap, 1 = saturate.
REQ-015 dataOut1  output  N  filtered sample.
REQ-016 r_out  output  1  output valid, single-cycle pulse per result.
REQ-017 ovf  output  1  sticky overflow flag.

Function
REQ-018 A sample is accepted on a rising edge where rIn1=1, enable=1 and clear=0.
REQ-019 For accepted samples x[n], the result is y[n] = sum over k=0..TAPS-1 of C[k]*x[n-k].
- Indexing counts accepted samples only, not clock cycles.
- Pre-load history is zero.
REQ-020 The accumulator is full precision: N+COEF_W+clog2(TAPS) bits, signed.
REQ-021 Output conversion:
- sat_mode=0: dataOut1 = low N bits of the accumulator.
- sat_mode=1: dataOut1 = accumulator clamped to [-2^(N-1), 2^(N-1)-1].
REQ-022 ovf is set on any result whose accumulator lies outside the signed N-bit range, in either mode.
- ovf holds until clear or reset.
REQ-023 The pipeline is two registered stages, so latency is exactly 2 enabled edges.
- A sample accepted at edge t produces r_out=1 with dataOut1 valid after edge t+2.
- r_out=1 lasts exactly one cycle.
REQ-024 Full throughput: one sample per cycle with no bubbles. Gaps in rIn1 produce matching gaps in r_out.
REQ-025 When enable=0, the delay line, pipeline, r_out, dataOut1 and ovf hold their values.
- A pending r_out=1 therefore persists until enable returns.
REQ-026 clear=1 takes priority over enable and rIn1.
- Zeroes the delay line, both pipeline stages and ovf.
- Drives r_out=0 on the next edge.
- Coefficients are retained.
REQ-027 A coefficient write occurs on any edge with coef_we=1 and coef_addr<TAPS, independent of enable and clear.
- A write with coef_addr>=TAPS is ignored.
REQ-028 A sample uses the coefficients present before its accepting edge.
- A write on that same edge applies from the next accepted sample.
- Results already in flight are unaffected by later writes.
REQ-029 rIn1 and coef_we asserted on the same edge are both honoured, with no interaction beyond REQ-028.

Reset
REQ-030 While rst=0, asynchronously:
- r_out=0, dataOut1=0, ovf=0.
- Delay line and pipeline zeroed.
- C[k] = TAPS-k, for k=0..TAPS-1 (default 4,3,2,1).
REQ-031 Reset mid-stream discards all in-flight results; no r_out pulse is produced for them after release.
REQ-032 First acceptance is possible on the first rising edge after rst deasserts.

Verification
REQ-033 Impulse: default coefficients; dataIn1 = 1, 0, 0, 0, 0 on consecutive valid cycles -> dataOut1 = 4, 3, 2, 1, 0, each 2 cycles after its input.
REQ-034 Step plus gaps: dataIn1 = 1 on every other cycle, 5 samples -> outputs 4, 7, 9, 10, 10, with r_out pulses on alternating cycles.
REQ-035 Overflow: dataIn1 = 0x7FFF repeated.
- sat_mode=0 -> first output 0xFFFC.
- sat_mode=1 -> 0x7FFF on every output.
- ovf=1 from the first result; clear -> ovf=0.
REQ-036 Coefficient load: write C[0]=0xFFFF, then impulse 1 -> outputs 0xFFFF, 3, 2, 1.
- A write to address TAPS changes nothing.
REQ-037 Stall and flush:
- enable=0 for 3 cycles mid-stream -> outputs and r_out held, no samples lost.
- clear mid-stream -> next impulse yields 4, 3, 2, 1 with no residue.
REQ-038 Async reset asserted between edges with results in flight -> outputs zero immediately, no stale r_out after release, coefficients back to 4, 3, 2, 1.
